// File: rtl/program_loader_if.sv
// Program-memory write port driven by program_loader.
// The loader owns the port (master); the memory wrapper observes it (slave).
interface program_loader_if;
  logic [31:0] programAddress;
  logic [7:0]  programByte;
  logic        programWrEn;

  modport master (output programAddress, output programByte, output programWrEn);
  modport slave  (input  programAddress, input  programByte, input  programWrEn);
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed program image over UART 8N1,
// writes it into the byte-wide program memory, then releases the CPU.
// Optional feature macro: PROGRAM_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the CPU is released.
//
// RX FSM   state    | meaning
//          RX_IDLE  | line idle, waiting for a low sample
//          RX_START | half-bit wait, confirm start bit still low
//          RX_DATA  | eight mid-bit samples, LSB first
//          RX_STOP  | stop-bit sample; high = byte_valid, low = framing error
// Loader   state    | meaning
//          LD_LEN_LO| waiting for length low byte
//          LD_LEN_HI| waiting for length high byte, range-check N
//          LD_DATA  | writing data bytes to address 0..N-1
//          LD_CHECK | waiting for checksum byte (checksum build only)
//          LD_DONE  | image loaded, CPU released, rx ignored
//          LD_ERROR | load failed, CPU held, rx ignored
module program_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_BYTES    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  program_loader_if.master  prog,
  output logic              startProgram,
  output logic              cpu_reset,
  output logic              load_error,
  output logic              busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]     MEM_MAX   = 17'(MEM_BYTES);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    LD_LEN_LO, LD_LEN_HI, LD_DATA,
`ifdef PROGRAM_CHECKSUM_EN
    LD_CHECK,
`endif
    LD_DONE, LD_ERROR
  } ld_state_t;

  logic          rx_meta, rx_sync;
  rx_state_t     rx_state, rx_nxt;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tc, stop_good, frame_bad, byte_valid;

  ld_state_t     ld_state, ld_nxt;
  logic [7:0]    len_lo;
  logic [15:0]   len, wr_cnt, n_rx;
`ifdef PROGRAM_CHECKSUM_EN
  logic [7:0]    xor_acc;
`endif

  assign tc   = (bit_cnt == '0);
  assign n_rx = {shreg, len_lo};

  // Two-flop synchronizer for the asynchronous serial input, idle-high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_nxt;
  end

  // RX next state plus stop-bit verdict (frame_bad feeds the loader directly)
  always_comb begin
    rx_nxt    = rx_state;
    stop_good = 1'b0;
    frame_bad = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_nxt = RX_START;
      RX_START: if (tc) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tc && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP: begin
        if (tc) begin
          rx_nxt    = RX_IDLE;
          stop_good = rx_sync;
          frame_bad = !rx_sync;
        end
      end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // Bit timer (down-counter, reloads on terminal count), bit index, shifter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= HALF_LAST;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= stop_good;
      if (rx_state == RX_IDLE) bit_cnt <= HALF_LAST;
      else if (tc)             bit_cnt <= BIT_LAST;
      else                     bit_cnt <= bit_cnt - 1'b1;
      if (rx_state == RX_START)      bit_idx <= '0;
      else if (rx_state == RX_DATA && tc) bit_idx <= bit_idx + 1'b1;
      if (rx_state == RX_DATA && tc) shreg <= {rx_sync, shreg[7:1]};
    end
  end

  // Loader state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ld_state <= LD_LEN_LO;
    else        ld_state <= ld_nxt;
  end

  // Loader next state; DATA lingers one cycle after the last write so the
  // release follows the final write strobe
  always_comb begin
    ld_nxt = ld_state;
    case (ld_state)
      LD_LEN_LO: if (byte_valid) ld_nxt = LD_LEN_HI;
      LD_LEN_HI: begin
        if (byte_valid)
          ld_nxt = (n_rx == 16'd0 || {1'b0, n_rx} > MEM_MAX) ? LD_ERROR : LD_DATA;
      end
`ifdef PROGRAM_CHECKSUM_EN
      LD_DATA:   if (wr_cnt == len) ld_nxt = LD_CHECK;
      LD_CHECK:  if (byte_valid) ld_nxt = (xor_acc == shreg) ? LD_DONE : LD_ERROR;
`else
      LD_DATA:   if (wr_cnt == len) ld_nxt = LD_DONE;
`endif
      LD_DONE:   ld_nxt = LD_DONE;
      LD_ERROR:  ld_nxt = LD_ERROR;
      default:   ld_nxt = LD_ERROR;
    endcase
    if (frame_bad && ld_state != LD_DONE) ld_nxt = LD_ERROR;
  end

  // Length capture and memory write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo              <= '0;
      len                 <= '0;
      wr_cnt              <= '0;
      prog.programWrEn    <= 1'b0;
      prog.programAddress <= '0;
      prog.programByte    <= '0;
`ifdef PROGRAM_CHECKSUM_EN
      xor_acc             <= '0;
`endif
    end else begin
      prog.programWrEn <= 1'b0;
      if (ld_state == LD_LEN_LO && byte_valid) len_lo <= shreg;
      if (ld_state == LD_LEN_HI && byte_valid) len    <= n_rx;
      if (ld_state == LD_DATA && byte_valid && wr_cnt != len) begin
        prog.programWrEn    <= 1'b1;
        prog.programAddress <= {16'd0, wr_cnt};
        prog.programByte    <= shreg;
        wr_cnt              <= wr_cnt + 1'b1;
`ifdef PROGRAM_CHECKSUM_EN
        xor_acc             <= xor_acc ^ shreg;
`endif
      end
    end
  end

  assign startProgram = (ld_state == LD_DONE);
  assign cpu_reset    = !startProgram;
  assign load_error   = (ld_state == LD_ERROR);
  assign busy         = !(ld_state == LD_LEN_LO || ld_state == LD_DONE || ld_state == LD_ERROR);

endmodule
